// File: rtl/key_cmd_pkg.sv
// ============================================================================
// Module : key_cmd_pkg
// Brief  : Shared game constants (clock, tick rate, debounce time) and helpers
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package key_cmd_pkg;

  localparam int c_CLK_HZ     = 100_000_000;
  localparam int c_TICK_HZ    = 20;
  localparam int c_TICK_DIV   = c_CLK_HZ / c_TICK_HZ;
  localparam int c_DEB_CYCLES = 1_000_000;

  // Width of a counter whose largest stored value is terminal-1; never zero.
  function automatic int cnt_width(input int terminal);
    return (terminal > 1) ? $clog2(terminal) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_debounce.sv
// ============================================================================
// Module : key_debounce
// Brief  : 2-flop synchronizer, counting debouncer and rising-edge detector
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debounce
  import key_cmd_pkg::*;
#(
  parameter int DEB_CYCLES = c_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_press
);

  localparam int             c_W    = cnt_width(DEB_CYCLES);
  localparam logic [c_W-1:0] c_LAST = c_W'(DEB_CYCLES - 1);

  logic           r_sync1;
  logic           r_sync2;
  logic           r_level;
  logic           r_level_d;
  logic [c_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_raw;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      // Any cycle agreeing with the accepted level restarts the stability count.
      if (r_sync2 != r_level) begin
        if (r_cnt == c_LAST) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_level & ~r_level_d;

endmodule

`default_nettype wire

// File: rtl/key_cmd.sv
// ============================================================================
// Module : key_cmd
// Brief  : Game tick divider plus latched jump/down requests and restart pulse
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_cmd
  import key_cmd_pkg::*;
#(
  parameter int TICK_DIV   = c_TICK_DIV,
  parameter int DEB_CYCLES = c_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic key_jump_raw,
  input  logic key_down_raw,
  input  logic dead,
  output logic tick_20,
  output logic kp_jump,
  output logic kp_down,
  output logic restart
);

  localparam int             c_TW    = cnt_width(TICK_DIV);
  localparam logic [c_TW-1:0] c_TLAST = c_TW'(TICK_DIV - 1);

  logic            w_press_jump;
  logic            w_press_down;
  logic            w_tick;
  logic [c_TW-1:0] r_tick_cnt;
  logic            r_jump_pend;
  logic            r_down_pend;
  logic            r_restart;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_jump (
    .clk     (clk),
    .rst     (rst),
    .i_raw   (key_jump_raw),
    .o_press (w_press_jump)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
    .clk     (clk),
    .rst     (rst),
    .i_raw   (key_down_raw),
    .o_press (w_press_down)
  );

  assign w_tick = (r_tick_cnt == c_TLAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  // A press landing in the tick cycle survives that tick and waits for the next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_jump_pend <= 1'b0;
      r_down_pend <= 1'b0;
      r_restart   <= 1'b0;
    end else begin
      r_restart <= dead & w_press_jump;
      if (dead) begin
        r_jump_pend <= 1'b0;
        r_down_pend <= 1'b0;
      end else begin
        r_jump_pend <= w_press_jump | (r_jump_pend & ~w_tick);
        r_down_pend <= w_press_down | (r_down_pend & ~w_tick);
      end
    end
  end

  assign tick_20 = w_tick;
  assign kp_jump = r_jump_pend;
  assign kp_down = r_down_pend & ~r_jump_pend;
  assign restart = r_restart;

endmodule

`default_nettype wire

// File: doc/key_cmd.md
KEY_CMD -- requirements
Module: key_cmd

Interface
REQ-001 Parameter TICK_DIV, default 5_000_000, is the clk cycles per game tick (100 MHz / 20 Hz).
REQ-002 Parameter DEB_CYCLES, default 1_000_000, is the consecutive stable cycles needed to accept a key change (10 ms).
REQ-003 Port clk  input  1  is the system clock; all logic is on its rising edge.
REQ-004 Port rst  input  1  is the reset: asynchronous, active-high.
REQ-005 Port key_jump_raw  input  1  is the asynchronous, bouncing jump key level (1 = pressed).
REQ-006 Port key_down_raw  input  1  is the asynchronous, bouncing down key level (1 = pressed).
REQ-007 Port dead  input  1  is the game-over level from the game logic.
REQ-008 Port tick_20  output  1  is a one-cycle game-tick strobe, every TICK_DIV cycles.
REQ-009 Port kp_jump  output  1  is the jump request, held until consumed by a tick.
REQ-010 Port kp_down  output  1  is the down request, held until consumed by a tick.
REQ-011 Port restart  output  1  is a one-cycle pulse for a jump press accepted while dead=1.

Function
REQ-012 Each raw key SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Per key: a debounced level SHALL take the synchronized value after DEB_CYCLES consecutive mismatching cycles; any matching cycle resets the count to 0.
REQ-014 A press event SHALL be a one-cycle pulse on the 0->1 transition of the debounced level; release SHALL produce no event.
REQ-015 The tick counter SHALL count 0..TICK_DIV-1 and wrap to 0; tick_20 SHALL be 1 exactly in cycles where the count equals TICK_DIV-1.
REQ-016 A press event with dead=0 SHALL set that key's pending flag at the next edge.
REQ-017 kp_jump SHALL equal jump_pending.
REQ-018 kp_down SHALL equal down_pending AND NOT jump_pending (jump has priority).
REQ-019 At the edge that ends a tick_20=1 cycle, both pending flags SHALL clear.
REQ-020 If a press event and tick_20 coincide, the press SHALL win: the flag is set and held until the following tick.
REQ-021 A repeated press while the flag is already pending SHALL have no further effect (no counting or queueing).
REQ-022 While dead=1, both pending flags SHALL clear at the next edge and down presses SHALL be dropped.
REQ-023 While dead=1, a jump press event SHALL produce restart=1 for exactly one cycle, the cycle after the event, and SHALL NOT set jump_pending.
REQ-024 Counter widths SHALL be $clog2 of their terminal value; counters SHALL never exceed their terminal value.

Reset
REQ-025 With rst=1, synchronizers, debounced levels (0), counters (0) and pending flags (0) SHALL clear asynchronously.
REQ-026 During reset, tick_20, kp_jump, kp_down and restart SHALL be 0.
REQ-027 A key held through reset SHALL produce a press event only after DEB_CYCLES post-reset stable cycles.
REQ-028 Reset mid-debounce or mid-tick SHALL discard all partial counts; the first tick_20 SHALL occur TICK_DIV cycles after reset release.

Structure
REQ-029 The default TICK_DIV and DEB_CYCLES SHALL live in the shared game package, alongside the 100 MHz clock constant.
REQ-030 Synchronizer + debouncer + edge detector SHALL be one sub-module, key_debounce, instantiated twice.
REQ-031 Tick divider and request latch SHALL be in key_cmd itself.

Verification (TICK_DIV=10, DEB_CYCLES=4)
REQ-032 Bounce: jump_raw toggles 1,0,1 one cycle each, then holds 1 -> exactly one press; kp_jump rises 2+4+1 cycles after the stable 1.
REQ-033 Hold/consume: jump press between ticks -> kp_jump stays 1 until the edge after the next tick_20, then 0; holding the key gives no second request.
REQ-034 Coincidence: press event in the tick_20 cycle -> kp_jump stays 1 through the following tick (10 cycles later), then clears.
REQ-035 Priority: jump and down both pending -> kp_jump=1, kp_down=0; after the tick both are 0.
REQ-036 Dead: dead=1 with down pending -> kp_down=0 next cycle; jump press gives restart=1 for one cycle and kp_jump stays 0.
REQ-037 Reset: assert rst on count 7 with a debounce in progress -> all outputs 0 immediately; the first tick_20 comes 10 cycles after release.
